// File: rtl/hostctrl_loader.sv
// Byte-serial boot loader: assembles address/data word pairs from a host
// handshake and writes them to memory over a Wishbone master port.
module hostctrl_loader #(
    parameter int WB_TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [7:0]  hostctrl_data,
    input  logic        hostctrl_valid,
    input  logic        hostctrl_done,
    output logic        hostctrl_ack_data,
    output logic        hostctrl_ack,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        cpu_rst_o,
    output logic        load_err_o,
    output logic [15:0] word_cnt_o
);

    localparam int TMO_W = $clog2(WB_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WB_TIMEOUT - 1);

    typedef enum logic [2:0] {
        RECV, BYTE_ACK, WB_WRITE, WORD_ACK, DONE
    } state_t;

    state_t           state;
    logic [2:0]       byte_cnt;
    logic [31:0]      addr_q;
    logic [31:0]      data_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic             skip_q;

    // Write-only master: read data is never consumed.
    logic unused_dat;
    assign unused_dat = ^wb_dat_i;

    // The received address is a word index; the bus wants a byte address.
    assign wb_adr_o = {addr_q[29:0], 2'b00};
    assign wb_dat_o = data_q;
    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent logic.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state             <= RECV;
            byte_cnt          <= '0;
            addr_q            <= '0;
            data_q            <= '0;
            tmo_cnt           <= '0;
            skip_q            <= 1'b0;
            word_cnt_o        <= '0;
            load_err_o        <= 1'b0;
            hostctrl_ack_data <= 1'b0;
            hostctrl_ack      <= 1'b0;
            wb_cyc_o          <= 1'b0;
            wb_stb_o          <= 1'b0;
            wb_we_o           <= 1'b0;
            wb_sel_o          <= 4'h0;
            cpu_rst_o         <= 1'b1;
        end else begin
            case (state)
                RECV: begin
                    if (skip_q) begin
                        // valid may still be high from the byte just acknowledged
                        skip_q <= 1'b0;
                    end else if (hostctrl_done && byte_cnt == 3'd0) begin
                        cpu_rst_o <= 1'b0;
                        state     <= DONE;
                    end else if (hostctrl_valid) begin
                        if (!byte_cnt[2])
                            addr_q[{byte_cnt[1:0], 3'b000} +: 8] <= hostctrl_data;
                        else
                            data_q[{byte_cnt[1:0], 3'b000} +: 8] <= hostctrl_data;
                        hostctrl_ack_data <= 1'b1;
                        state             <= BYTE_ACK;
                    end
                end
                BYTE_ACK: begin
                    if (!hostctrl_valid) begin
                        hostctrl_ack_data <= 1'b0;
                        if (byte_cnt == 3'd7) begin
                            byte_cnt <= '0;
                            tmo_cnt  <= '0;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= 1'b1;
                            wb_sel_o <= 4'hF;
                            state    <= WB_WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                            skip_q   <= 1'b1;
                            state    <= RECV;
                        end
                    end
                end
                WB_WRITE: begin
                    if (wb_err_i || wb_ack_i || tmo_cnt == TMO_LAST) begin
                        wb_cyc_o     <= 1'b0;
                        wb_stb_o     <= 1'b0;
                        wb_we_o      <= 1'b0;
                        wb_sel_o     <= 4'h0;
                        hostctrl_ack <= 1'b1;
                        // err wins over a simultaneous ack; no response means timeout
                        if (wb_err_i || !wb_ack_i)
                            load_err_o <= 1'b1;
                        else
                            word_cnt_o <= word_cnt_o + 16'd1;
                        state <= WORD_ACK;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WORD_ACK: begin
                    if (hostctrl_valid || hostctrl_done) begin
                        hostctrl_ack <= 1'b0;
                        state        <= RECV;
                    end
                end
                DONE: begin
                    hostctrl_ack_data <= 1'b0;
                    hostctrl_ack      <= 1'b0;
                    cpu_rst_o         <= 1'b0;
                end
                default: state <= RECV;
            endcase
        end
    end

endmodule

// File: tb/tb_hostctrl_loader.sv
// Directed bench for hostctrl_loader: host byte handshake driver plus a
// Wishbone slave model with selectable ack/err/silent behaviour.
module tb_hostctrl_loader;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i = 1'b0;
    logic [7:0]  hostctrl_data = '0;
    logic        hostctrl_valid = 1'b0;
    logic        hostctrl_done = 1'b0;
    logic        hostctrl_ack_data, hostctrl_ack;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        cpu_rst_o, load_err_o;
    logic [15:0] word_cnt_o;

    hostctrl_loader #(.WB_TIMEOUT(255)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .hostctrl_data(hostctrl_data), .hostctrl_valid(hostctrl_valid),
        .hostctrl_done(hostctrl_done), .hostctrl_ack_data(hostctrl_ack_data),
        .hostctrl_ack(hostctrl_ack),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .cpu_rst_o(cpu_rst_o), .load_err_o(load_err_o), .word_cnt_o(word_cnt_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef enum {S_ACK, S_ERR, S_BOTH, S_NONE} slave_mode_t;
    slave_mode_t slave_mode = S_ACK;
    int          ack_delay = 0;
    int          stb_cycles = 0;
    int          last_len = 0;
    int          writes = 0;
    logic [31:0] last_adr = '0, last_dat = '0;
    logic [3:0]  last_sel = '0;
    logic        last_we = 1'b0;
    int          byte_acks = 0;
    logic        prev_ack_data = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave responds on the (ack_delay+1)-th cycle of a strobe.
    always @(negedge wb_clk_i) begin
        if (wb_cyc_o && wb_stb_o) begin
            stb_cycles++;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (stb_cycles == ack_delay + 1) begin
                case (slave_mode)
                    S_ACK: begin
                        wb_ack_i = 1'b1;
                        writes++;
                        last_adr = wb_adr_o;
                        last_dat = wb_dat_o;
                        last_sel = wb_sel_o;
                        last_we  = wb_we_o;
                    end
                    S_ERR:  wb_err_i = 1'b1;
                    S_BOTH: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; end
                    default: ;
                endcase
            end
        end else begin
            if (stb_cycles > 0) last_len = stb_cycles;
            stb_cycles = 0;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
        end
        if (hostctrl_ack_data && !prev_ack_data) byte_acks++;
        prev_ack_data = hostctrl_ack_data;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge wb_clk_i);
    endtask

    task automatic do_reset();
        wb_rst_n_i = 1'b0;
        tick(2);
        wb_rst_n_i = 1'b1;
        writes = 0;
        byte_acks = 0;
        last_adr = '0;
        last_dat = '0;
        last_len = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        int n;
        hostctrl_data  = b;
        hostctrl_valid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!hostctrl_ack_data && n < 20);
        if (!hostctrl_ack_data) check("byte_ack_rise", hostctrl_ack_data, 1);
        tick(hold);
        hostctrl_valid = 1'b0;
        n = 0;
        do begin tick(); n++; end while (hostctrl_ack_data && n < 20);
        if (hostctrl_ack_data) check("byte_ack_fall", hostctrl_ack_data, 0);
    endtask

    task automatic send_bytes(input logic [31:0] a, input logic [31:0] d,
                              input int first, input int last, input int hold0);
        logic [63:0] w;
        w = {d, a};
        for (int i = first; i <= last; i++)
            send_byte(w[i*8 +: 8], (i == 0) ? hold0 : 0);
    endtask

    task automatic wait_word_ack(input string tag, input int budget);
        int n;
        n = 0;
        while (!hostctrl_ack && n < budget) begin tick(); n++; end
        check(tag, hostctrl_ack, 1);
    endtask

    initial begin
        int n;
        // Reset values
        tick(2);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_we", wb_we_o, 0);
        check("rst_sel", wb_sel_o, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_cti", wb_cti_o, 0);
        check("rst_bte", wb_bte_o, 0);
        check("rst_ack_data", hostctrl_ack_data, 0);
        check("rst_ack", hostctrl_ack, 0);
        check("rst_cpu_rst", cpu_rst_o, 1);
        check("rst_load_err", load_err_o, 0);
        check("rst_word_cnt", word_cnt_o, 0);
        wb_rst_n_i = 1'b1;

        // Single word; first byte held valid for 10 cycles
        slave_mode = S_ACK; ack_delay = 0;
        send_bytes(32'h0000_0040, 32'hDEAD_BEEF, 0, 0, 9);
        check("long_valid_one_byte", byte_acks, 1);
        send_bytes(32'h0000_0040, 32'hDEAD_BEEF, 1, 7, 0);
        wait_word_ack("w1_hostctrl_ack", 50);
        tick();
        check("w1_byte_acks", byte_acks, 8);
        check("w1_writes", writes, 1);
        check("w1_adr", last_adr, 32'h0000_0100);
        check("w1_dat", last_dat, 32'hDEAD_BEEF);
        check("w1_sel", last_sel, 4'hF);
        check("w1_we", last_we, 1);
        check("w1_stb_len", last_len, 1);
        check("w1_ack_held", hostctrl_ack, 1);
        check("w1_word_cnt", word_cnt_o, 1);
        check("w1_load_err", load_err_o, 0);
        check("w1_cpu_rst", cpu_rst_o, 1);

        // Ack three cycles late
        ack_delay = 3;
        send_bytes(32'h1234_5678, 32'hA5A5_5A5A, 0, 7, 0);
        wait_word_ack("w2_hostctrl_ack", 50);
        tick();
        check("w2_writes", writes, 2);
        check("w2_adr", last_adr, 32'h48D1_59E0);
        check("w2_dat", last_dat, 32'hA5A5_5A5A);
        check("w2_stb_len", last_len, 4);
        check("w2_load_err", load_err_o, 0);
        check("w2_word_cnt", word_cnt_o, 2);

        // Silent slave: timeout
        slave_mode = S_NONE; ack_delay = 0;
        send_bytes(32'h0000_0001, 32'h0000_0002, 0, 7, 0);
        wait_word_ack("tmo_hostctrl_ack", 400);
        tick();
        check("tmo_stb_len", last_len, 255);
        check("tmo_load_err", load_err_o, 1);
        check("tmo_word_cnt", word_cnt_o, 2);
        check("tmo_cyc", wb_cyc_o, 0);
        check("tmo_writes", writes, 2);

        // Ack and err together count as an error
        do_reset();
        slave_mode = S_BOTH;
        send_bytes(32'h0000_0003, 32'h0000_0004, 0, 7, 0);
        wait_word_ack("both_hostctrl_ack", 50);
        tick();
        check("both_load_err", load_err_o, 1);
        check("both_word_cnt", word_cnt_o, 0);

        // done raised mid-word: word must complete before DONE
        do_reset();
        slave_mode = S_ACK;
        send_bytes(32'h0000_0010, 32'h1122_3344, 0, 2, 0);
        hostctrl_done = 1'b1;
        tick(5);
        check("partial_cpu_rst", cpu_rst_o, 1);
        check("partial_ack_data", hostctrl_ack_data, 0);
        send_bytes(32'h0000_0010, 32'h1122_3344, 3, 7, 0);
        n = 0;
        while (cpu_rst_o && n < 50) begin tick(); n++; end
        check("done_cpu_rst", cpu_rst_o, 0);
        check("done_writes", writes, 1);
        check("done_adr", last_adr, 32'h0000_0040);
        check("done_dat", last_dat, 32'h1122_3344);
        check("done_word_cnt", word_cnt_o, 1);
        hostctrl_done = 1'b0;
        hostctrl_valid = 1'b1;
        tick(5);
        check("done_ignores_valid", hostctrl_ack_data, 0);
        check("done_ack", hostctrl_ack, 0);
        check("done_cyc", wb_cyc_o, 0);
        check("done_stays", cpu_rst_o, 0);
        hostctrl_valid = 1'b0;

        // Reset in the middle of a bus cycle
        do_reset();
        slave_mode = S_NONE;
        send_bytes(32'h0000_0005, 32'h0000_0006, 0, 7, 0);
        tick(10);
        check("mid_cyc_before", wb_cyc_o, 1);
        wb_rst_n_i = 1'b0;
        tick();
        check("mid_rst_cyc", wb_cyc_o, 0);
        check("mid_rst_stb", wb_stb_o, 0);
        check("mid_rst_cpu_rst", cpu_rst_o, 1);
        check("mid_rst_word_cnt", word_cnt_o, 0);
        check("mid_rst_adr", wb_adr_o, 0);
        wb_rst_n_i = 1'b1;
        tick();
        slave_mode = S_ACK;
        writes = 0;
        send_bytes(32'h0000_0007, 32'h0000_0008, 0, 7, 0);
        wait_word_ack("post_rst_hostctrl_ack", 50);
        tick();
        check("post_rst_adr", last_adr, 32'h0000_001C);
        check("post_rst_dat", last_dat, 32'h0000_0008);
        check("post_rst_word_cnt", word_cnt_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/hostctrl_loader.md
HOSTCTRL_LOADER -- requirements
Module: hostctrl_loader

Interface
REQ-001 SHALL have parameter WB_TIMEOUT, default 255: max cycles to wait for wb_ack_i/wb_err_i before the write is aborted.
REQ-002 SHALL have port wb_clk_i, input, 1: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port wb_rst_n_i, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port hostctrl_data, input, 8: byte from the host.
REQ-005 SHALL have port hostctrl_valid, input, 1: hostctrl_data is valid.
REQ-006 SHALL have port hostctrl_done, input, 1: the host has no more words to send.
REQ-007 SHALL have port hostctrl_ack_data, output, 1: byte accepted.
REQ-008 SHALL have port hostctrl_ack, output, 1: address/data word pair written to memory.
REQ-009 SHALL have Wishbone master outputs: wb_adr_o 32, wb_dat_o 32, wb_sel_o 4, wb_we_o 1, wb_cyc_o 1, wb_stb_o 1, wb_cti_o 3, wb_bte_o 2.
REQ-010 SHALL have Wishbone master inputs: wb_dat_i 32 (unused), wb_ack_i 1, wb_err_i 1.
REQ-011 SHALL have port cpu_rst_o, output, 1: holds the CPU in reset until loading is complete.
REQ-012 SHALL have port load_err_o, output, 1: sticky error flag, set by a bus error or a timeout.
REQ-013 SHALL have port word_cnt_o, output, 16: number of words written, wrapping modulo 2^16.

Function
REQ-014 SHALL implement the states RECV, BYTE_ACK, WB_WRITE, WORD_ACK and DONE.
REQ-015 SHALL, in RECV with hostctrl_valid=1, store hostctrl_data at byte index byte_cnt[1:0] of the address register (byte_cnt<4) or of the data register (byte_cnt>=4), LSB first, and then go to BYTE_ACK.
REQ-016 SHALL hold hostctrl_ack_data=1 for every cycle it is in BYTE_ACK; this is a four-phase handshake.
REQ-017 SHALL, in BYTE_ACK with hostctrl_valid=0, increment byte_cnt; when byte_cnt was 7 it goes to WB_WRITE and clears byte_cnt, otherwise it returns to RECV.
REQ-018 SHALL, in RECV, ignore hostctrl_valid for one cycle after returning from BYTE_ACK, so that no byte is captured twice.
REQ-019 SHALL, in WB_WRITE, assert wb_cyc_o=wb_stb_o=wb_we_o=1 with wb_sel_o=4'hF, wb_cti_o=3'b000 and wb_bte_o=2'b00.
REQ-020 SHALL drive wb_adr_o={addr[29:0],2'b00} (the received address is a word index) and wb_dat_o equal to the data register.
REQ-021 SHALL, on wb_ack_i, deassert cyc/stb/we in the next cycle, increment word_cnt_o and go to WORD_ACK.
REQ-022 SHALL, on wb_err_i, or when the timeout counter reaches WB_TIMEOUT, do the same as REQ-021 except that word_cnt_o is not incremented, and set load_err_o.
REQ-023 SHALL, when wb_ack_i and wb_err_i are both high in the same cycle, treat the cycle as an error.
REQ-024 SHALL hold hostctrl_ack=1 for every cycle it is in WORD_ACK, and return to RECV when hostctrl_valid=1 or hostctrl_done=1; the byte is not captured on that exit cycle.
REQ-025 SHALL go from RECV to DONE when hostctrl_done=1 and byte_cnt=0; hostctrl_done takes priority over hostctrl_valid.
REQ-026 SHALL ignore hostctrl_done in RECV while byte_cnt!=0, so that a partial word is completed first.
REQ-027 SHALL remain in DONE until reset, with cpu_rst_o=0 and all handshake outputs 0.
REQ-028 SHALL hold cpu_rst_o=1 in every state other than DONE.
REQ-029 SHALL drive all outputs from registers.

Reset
REQ-030 SHALL, while wb_rst_n_i=0 at a clock edge, enter RECV and clear byte_cnt, the address and data registers, the timeout counter, word_cnt_o and load_err_o.
REQ-031 SHALL drive every output to 0 during reset, except cpu_rst_o=1 and wb_cti_o=3'b000.
REQ-032 SHALL, if reset is applied in the middle of a Wishbone cycle, drop wb_cyc_o/wb_stb_o in the next cycle and discard the partial word.

Verification
REQ-033 SHALL cover a single word: bytes 40,00,00,00 then EF,BE,AD,DE, each handshaken -> one write with wb_adr_o=0x00000100 and wb_dat_o=0xDEADBEEF, hostctrl_ack high, word_cnt_o=1.
REQ-034 SHALL cover a slave whose ack arrives 3 cycles late -> stb held stable for 4 cycles, exactly one write, load_err_o=0.
REQ-035 SHALL cover a slave that never responds -> after 255 cycles cyc drops, load_err_o=1, hostctrl_ack asserted, word_cnt_o unchanged.
REQ-036 SHALL cover hostctrl_done raised after 3 bytes -> no transition to DONE until 8 bytes and the write have completed; then cpu_rst_o=0.
REQ-037 SHALL cover hostctrl_valid held high for 10 cycles -> exactly one byte captured, byte_cnt advances by 1.
REQ-038 SHALL cover wb_rst_n_i=0 during WB_WRITE -> next cycle wb_cyc_o=0, state RECV, word_cnt_o=0, cpu_rst_o=1.
